// File: rtl/bounce_emulator_pkg.sv
// Shared definitions for the bounce emulator: FSM encoding, LFSR constants
// and the LFSR step function.
package bounce_emulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GLITCH = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam int          LFSR_W            = 16;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Galois step: shift right, fold the taps in when a one falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] shifted;
        shifted = {1'b0, s[15:1]};
        return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// Free-running 16-bit Galois LFSR; reusable for other stimulus generators.
module lfsr16
    import bounce_emulator_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic [15:0] o_State
);

    logic [15:0] state_q;

    // Advance every clock outside reset.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= SEED;
        end else begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign o_State = state_q;

endmodule

// File: rtl/bounce_emulator.sv
// Mechanical-switch emulator: turns a clean target level into a burst of
// toggles followed by a stable settle period.
module bounce_emulator
    import bounce_emulator_pkg::*;
#(
    parameter int          BOUNCE_COUNT  = 4,
    parameter int          GLITCH_LEN_W  = 3,
    parameter int          RANDOM_LEN    = 1,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Target,
    input  logic i_Enable,
    output logic o_Bouncy,
    output logic o_Busy,
    output logic o_Settled
);

    localparam int TOG_W = (BOUNCE_COUNT > 0) ? $clog2(2 * BOUNCE_COUNT + 1) : 1;
    localparam int LEN_W = GLITCH_LEN_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TOG_W-1:0] TOG_INIT    = TOG_W'(2 * BOUNCE_COUNT);
    localparam logic [LEN_W-1:0] FIXED_LEN   = LEN_W'(2 ** GLITCH_LEN_W);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES);
    localparam bit               NO_BOUNCE   = (BOUNCE_COUNT == 0);

    state_e           state_q;
    logic             target_q;
    logic [TOG_W-1:0] toggles_q;
    logic [LEN_W-1:0] len_q;
    logic [SET_W-1:0] settle_q;
    logic             bouncy_q;
    logic             busy_q;
    logic             settled_q;
    logic [LEN_W-1:0] seg_len_d;
    logic [15:0]      lfsr_state_s;
    logic             lfsr_unused_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .o_State (lfsr_state_s)
    );

    // Only the low GLITCH_LEN_W bits feed the segment length.
    assign lfsr_unused_s = ^lfsr_state_s;

    // Length of the next glitch segment, 1..2^GLITCH_LEN_W cycles.
    always_comb begin
        if (RANDOM_LEN != 0) begin
            seg_len_d = {1'b0, lfsr_state_s[GLITCH_LEN_W-1:0]} + LEN_W'(1);
        end else begin
            seg_len_d = FIXED_LEN;
        end
    end

    // Burst FSM with registered outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            target_q  <= 1'b0;
            toggles_q <= '0;
            len_q     <= '0;
            settle_q  <= '0;
            bouncy_q  <= 1'b0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            settled_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_Target != bouncy_q) begin
                        bouncy_q <= i_Target;
                        if (!i_Enable || NO_BOUNCE) begin
                            settled_q <= 1'b1;
                        end else begin
                            target_q  <= i_Target;
                            busy_q    <= 1'b1;
                            toggles_q <= TOG_INIT;
                            len_q     <= seg_len_d;
                            state_q   <= ST_GLITCH;
                        end
                    end
                end
                ST_GLITCH: begin
                    if (len_q == LEN_W'(1)) begin
                        bouncy_q  <= ~bouncy_q;
                        toggles_q <= toggles_q - TOG_W'(1);
                        // An even toggle count leaves the contact at target_q.
                        if (toggles_q == TOG_W'(1)) begin
                            settle_q <= SETTLE_INIT;
                            state_q  <= ST_SETTLE;
                        end else begin
                            len_q <= seg_len_d;
                        end
                    end else begin
                        len_q <= len_q - LEN_W'(1);
                    end
                end
                ST_SETTLE: begin
                    bouncy_q <= target_q;
                    if (settle_q == SET_W'(1)) begin
                        settle_q  <= '0;
                        busy_q    <= 1'b0;
                        settled_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Bouncy  = bouncy_q;
    assign o_Busy    = busy_q;
    assign o_Settled = settled_q;

endmodule
